// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared types and constants for the picorv32-to-RAM bridge
package mem_bridge_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
    localparam logic [3:0] WSTRB_NONE = 4'b0000;
    localparam logic [3:0] WSTRB_ALL = 4'b1111;
    localparam int DATA_W = 32;
    localparam int WCNT_W = 4;
    localparam int MAX_WAIT = (1 << WCNT_W) - 1;
endpackage

// File: rtl/mem_bridge_decode.sv
// mem_bridge_decode: byte address to RAM word index plus range check
module mem_bridge_decode
    import mem_bridge_pkg::*;
#(
    parameter int WORDS = 32,
    parameter int ADDR_W = 5,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic [DATA_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] idx,
    output logic              in_range
);
    logic [DATA_W-1:0] off;
    logic unused_off;
    always_comb begin
        off = mem_addr - BASE_ADDR;
        idx = off[ADDR_W+1:2];
        in_range = (mem_addr >= BASE_ADDR) && ({2'b00, off[31:2]} < 32'(WORDS));
    end
    assign unused_off = ^off[1:0];
endmodule

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: valid/ready bridge from picorv32 native bus to a registered-read word RAM
// with optional wait states and out-of-range flagging.
module mem_bus_bridge
    import mem_bridge_pkg::*;
#(
    parameter int WORDS = 32,
    parameter int ADDR_W = 5,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              bus_error,
    output logic              err_sticky
);
    state_t state, state_nx;
    logic [WCNT_W-1:0] wcnt;
    logic [ADDR_W-1:0] idx, idx_q, addr_last;
    logic [31:0] wdata_q, wdata_last;
    logic [3:0] wstrb_q;
    logic in_range, in_range_q;
    logic unused_instr;

    assign unused_instr = mem_instr;

    mem_bridge_decode #(.WORDS(WORDS), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_decode (
        .mem_addr(mem_addr),
        .idx(idx),
        .in_range(in_range)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !mem_valid ? IDLE : (WAIT_STATES > 0) ? WAIT : ACCESS;
            WAIT:    state_nx = (wcnt == '0) ? ACCESS : WAIT;
            ACCESS:  state_nx = RESP;
            default: state_nx = IDLE;
        endcase
        mem_ready = state == RESP;
        bus_error = mem_ready && !in_range_q;
        mem_rdata = (mem_ready && in_range_q) ? ram_rdata : '0;
        // reset gates the strobes combinationally so a write is never half-committed
        ram_wen = (state == ACCESS && in_range_q && !reset) ? wstrb_q : WSTRB_NONE;
        ram_addr = (state == ACCESS) ? idx_q : addr_last;
        ram_wdata = (state == ACCESS) ? wdata_q : wdata_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            wcnt <= '0;
            idx_q <= '0;
            wstrb_q <= WSTRB_NONE;
            wdata_q <= '0;
            in_range_q <= 1'b0;
            addr_last <= '0;
            wdata_last <= '0;
            err_sticky <= 1'b0;
        end else begin
            state <= state_nx;
            addr_last <= ram_addr;
            wdata_last <= ram_wdata;
            if (bus_error) err_sticky <= 1'b1;
            if (state == IDLE && mem_valid) begin
                idx_q <= idx;
                wstrb_q <= mem_wstrb;
                wdata_q <= mem_wdata;
                in_range_q <= in_range;
                wcnt <= WCNT_W'(WAIT_STATES - 1);
            end else if (state == WAIT) begin
                wcnt <= wcnt - WCNT_W'(1);
            end
        end
    end
endmodule

// File: doc/mem_bus_bridge.md
Name: mem_bus_bridge

Overview:
- Sits between the picorv32 native memory interface and the synchronous single-port word RAM.
- Replaces the hard-wired mem_ready=1 with a proper valid/ready handshake that respects the RAM's one-cycle registered read latency.
- Adds optional wait states and address-range checking. Out-of-range accesses are flagged, never written, and return zero.

Parameters:
- WORDS, 32, number of 32-bit words in the attached RAM.
- ADDR_W, 5, RAM word-address width; must satisfy 2**ADDR_W >= WORDS.
- BASE_ADDR, 32'h0000_0000, byte address of RAM word 0; must be 4-byte aligned.
- WAIT_STATES, 0, extra idle cycles inserted before each RAM access (0..15).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- mem_valid  input  1  CPU request valid; held high until mem_ready
- mem_instr  input  1  CPU instruction-fetch flag; informational, not used by the bridge
- mem_addr  input  32  CPU byte address
- mem_wdata  input  32  CPU write data
- mem_wstrb  input  4  CPU byte strobes; 0 means read
- mem_ready  output  1  one-cycle completion pulse to the CPU
- mem_rdata  output  32  read data, valid while mem_ready=1
- ram_wen  output  4  RAM byte write enables
- ram_addr  output  ADDR_W  RAM word address
- ram_wdata  output  32  RAM write data
- ram_rdata  input  32  RAM registered read data
- bus_error  output  1  one-cycle pulse with mem_ready when the access is out of range
- err_sticky  output  1  set on any bus_error; cleared only by reset

Behaviour:
- Reset values:
  - state=IDLE.
  - mem_ready, bus_error, err_sticky=0.
  - ram_wen=0, ram_addr=0, ram_wdata=0.
  - mem_rdata=0.
- Index computation: off = mem_addr - BASE_ADDR; idx = off[31:2]; in_range = (mem_addr >= BASE_ADDR) && (idx < WORDS). Bits [1:0] are ignored; there is no misalign trap.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - On mem_valid=1, latch idx, mem_wstrb, mem_wdata and in_range.
  - Go to WAIT with wcnt=WAIT_STATES-1 if WAIT_STATES>0; otherwise go to ACCESS.
  - If mem_valid=0, stay in IDLE.
- WAIT: decrement wcnt; move to ACCESS when wcnt==0. ram_wen=0 throughout.
- ACCESS (exactly one cycle):
  - ram_addr = latched idx.
  - ram_wen = in_range ? latched wstrb : 4'b0.
  - ram_wdata = latched wdata.
  - Next state is RESP.
- RESP (exactly one cycle):
  - mem_ready=1.
  - mem_rdata = in_range ? ram_rdata : 32'h0.
  - bus_error = !in_range.
  - err_sticky is set if !in_range.
  - Next state is IDLE.
- Latency:
  - mem_valid first seen high in cycle 0 → mem_ready high in cycle 2+WAIT_STATES.
  - Back-to-back accesses: the next request is accepted in the IDLE cycle immediately after RESP.
- Outside ACCESS: ram_wen=0 in every cycle; ram_addr holds its last value.
- mem_ready is never high for two consecutive cycles.
- Changes to mem_addr, mem_wdata or mem_wstrb after acceptance are ignored, because the latched copies are used.
- Write completion: mem_rdata is driven from ram_rdata (old word contents); the CPU ignores it.
- Reset mid-operation:
  - reset=1 in any cycle forces ram_wen=0 combinationally in that cycle, so there is no partial write.
  - The next state is IDLE. A pending request is dropped and no mem_ready is issued.
- mem_valid deasserted mid-transaction (protocol violation): the transaction still completes and mem_ready still pulses.

Decomposition:
- Package mem_bridge_pkg:
  - state enum {IDLE, WAIT, ACCESS, RESP}.
  - WSTRB_NONE=4'b0000 and WSTRB_ALL=4'b1111.
  - Width-check helper constants.
- One sub-module, mem_bridge_decode: combinational; mem_addr → {idx[ADDR_W-1:0], in_range}, parameterized by BASE_ADDR and WORDS.
- The FSM and latches stay in mem_bus_bridge.

Test Plan:
1. WAIT_STATES=0. Read with mem_addr=0x0000_0010, RAM word 4 preloaded 0xDEADBEEF → ram_addr=4 in cycle 1, mem_ready=1 and mem_rdata=0xDEADBEEF in cycle 2, bus_error=0.
2. Write mem_addr=0x0000_0008, mem_wstrb=4'b0101, mem_wdata=0x11223344 over word 2=0xAAAAAAAA → single ACCESS cycle with ram_wen=0101; read-back returns 0xAA22AA44.
3. Out-of-range write to mem_addr=0x0000_0080 (idx 32, WORDS=32) → ram_wen stays 0 throughout; mem_ready, bus_error=1 and mem_rdata=0 in cycle 2; err_sticky=1 afterwards.
4. WAIT_STATES=3, read of word 0 → mem_ready in cycle 5 exactly; ram_wen=0 for cycles 0–5.
5. Back-to-back: read word 1 then immediately write word 1 = 0xCAFEF00D, then read word 1 → mem_ready pulses at cycles 2, 5 and 8; final mem_rdata=0xCAFEF00D; mem_ready never high two cycles running.
6. Assert reset during the ACCESS cycle of a write to word 3 (old value 0x12345678) → no mem_ready; word 3 still reads back 0x12345678; all outputs return to their reset values.
